// File: rtl/fetch_if.sv
// fetch_if: decoder, instruction-memory and control signals of the fetch stage
interface fetch_if #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 start_i;
  logic [PC_WIDTH-1:0]  start_addr_i;
  logic [PC_WIDTH-1:0]  imem_addr_o;
  logic [7:0]           imem_data_i;
  logic [7:0]           instruction_o;
  logic                 instr_valid_o;
  logic                 branchf_i;
  logic                 branchb_i;
  logic                 done_i;
  logic [7:0]           branch_offset_i;
  logic [PC_WIDTH-1:0]  pc_o;
  logic                 busy_o;
  logic                 halted_o;
  logic [CNT_WIDTH-1:0] instr_count_o;
  modport master (
    input  start_i, start_addr_i, imem_data_i, branchf_i, branchb_i, done_i, branch_offset_i,
    output imem_addr_o, instruction_o, instr_valid_o, pc_o, busy_o, halted_o, instr_count_o
  );
  modport slave (
    output start_i, start_addr_i, imem_data_i, branchf_i, branchb_i, done_i, branch_offset_i,
    input  imem_addr_o, instruction_o, instr_valid_o, pc_o, busy_o, halted_o, instr_count_o
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and two-cycle fetch/exec sequencer ahead of the decoder
module fetch_unit #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input logic      clock_i,
  input logic      reset_n_i,
  fetch_if.master  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
  state_t               state, state_n;
  logic [PC_WIDTH-1:0]  pc, pc_n, off;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  assign off               = PC_WIDTH'(bus.branch_offset_i);
  assign bus.imem_addr_o   = pc;
  assign bus.pc_o          = pc;
  assign bus.instr_valid_o = state == EXEC;
  assign bus.instruction_o = state == EXEC ? bus.imem_data_i : 8'h88;
  assign bus.busy_o        = state == FETCH || state == EXEC;
  assign bus.halted_o      = state == HALTED;
  assign bus.instr_count_o = cnt;
  // state, PC and retired count; reset discards any in-flight instruction
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
    end
  // start acceptance, fetch/exec alternation and next-PC selection (done > branchf > branchb > +1)
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    if ((state == IDLE || state == HALTED) && bus.start_i) begin
      state_n = FETCH;
      pc_n    = bus.start_addr_i;
      cnt_n   = '0;
    end else if (state == FETCH) begin
      state_n = EXEC;
    end else if (state == EXEC) begin
      cnt_n   = &cnt ? cnt : cnt + CNT_WIDTH'(1);
      state_n = bus.done_i ? HALTED : FETCH;
      pc_n    = bus.done_i    ? pc :
                bus.branchf_i ? pc + off :
                bus.branchb_i ? pc - off :
                                pc + PC_WIDTH'(1);
    end
  end
endmodule
